// File: rtl/best_stream.sv
// best_stream: streaming per-generation best selector with all-time tracking.
// Ports: clk, rst_n, clear, mode_min, in_valid/in_ready/in_fitness/in_last,
//   out_valid/out_ready, best_index, best_fitness, gen_count,
//   all_best_fitness, all_best_index, all_best_gen, all_valid, len_err.
module best_stream #(
  parameter int WIDTH = 27,
  parameter int N     = 16,
  parameter int IDX_W = 8,
  parameter int GEN_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    mode_min,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_fitness,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        best_index,
  output logic signed [WIDTH-1:0] best_fitness,
  output logic [GEN_W-1:0]        gen_count,
  output logic signed [WIDTH-1:0] all_best_fitness,
  output logic [IDX_W-1:0]        all_best_index,
  output logic [GEN_W-1:0]        all_best_gen,
  output logic                    all_valid,
  output logic                    len_err
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  logic [IDX_W-1:0]        r_cnt;
  logic [GEN_W-1:0]        r_gen;
  logic                    r_mode;
  logic signed [WIDTH-1:0] r_run_fit;
  logic [IDX_W-1:0]        r_run_idx;
  logic                    r_out_valid;
  logic [IDX_W-1:0]        r_best_idx;
  logic signed [WIDTH-1:0] r_best_fit;
  logic [GEN_W-1:0]        r_gen_count;
  logic signed [WIDTH-1:0] r_all_fit;
  logic [IDX_W-1:0]        r_all_idx;
  logic [GEN_W-1:0]        r_all_gen;
  logic                    r_all_valid;
  logic                    r_len_err;

  logic                    w_ready;
  logic                    w_acc;
  logic                    w_first;
  logic                    w_mode;
  logic                    w_take;
  logic signed [WIDTH-1:0] w_cand_fit;
  logic [IDX_W-1:0]        w_cand_idx;
  logic                    w_at_last;
  logic                    w_end;
  logic                    w_all_take;

  assign w_ready   = !r_out_valid || out_ready;
  // A clear in the same cycle discards the sample.
  assign w_acc     = in_valid && w_ready && !clear;
  assign w_first   = (r_cnt == '0);
  // The mode latched for this generation; on the first sample it is live.
  assign w_mode    = w_first ? mode_min : r_mode;
  // First sample always loads so the most negative value can win.
  assign w_take    = w_first ||
                     (w_mode ? (in_fitness < r_run_fit)
                             : (in_fitness > r_run_fit));
  assign w_cand_fit = w_take ? in_fitness : r_run_fit;
  assign w_cand_idx = w_take ? r_cnt : r_run_idx;
  assign w_at_last  = (r_cnt == LAST);
  assign w_end      = w_acc && (w_at_last || in_last);
  assign w_all_take = !r_all_valid ||
                      (w_mode ? (w_cand_fit < r_all_fit)
                              : (w_cand_fit > r_all_fit));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_gen       <= '0;
      r_mode      <= 1'b0;
      r_run_fit   <= '0;
      r_run_idx   <= '0;
      r_best_idx  <= '0;
      r_best_fit  <= '0;
      r_gen_count <= '0;
      r_all_fit   <= '0;
      r_all_idx   <= '0;
      r_all_gen   <= '0;
      r_all_valid <= 1'b0;
      r_len_err   <= 1'b0;
    end else if (clear) begin
      r_cnt       <= '0;
      r_gen       <= '0;
      r_all_fit   <= '0;
      r_all_idx   <= '0;
      r_all_gen   <= '0;
      r_all_valid <= 1'b0;
    end else if (w_acc) begin
      r_run_fit <= w_cand_fit;
      r_run_idx <= w_cand_idx;
      if (w_first) r_mode <= mode_min;
      // Length mismatch: last flag early, or missing at index N-1.
      if (w_at_last != in_last) r_len_err <= 1'b1;
      if (w_end) begin
        r_cnt       <= '0;
        r_best_idx  <= w_cand_idx;
        r_best_fit  <= w_cand_fit;
        r_gen_count <= r_gen;
        r_gen       <= r_gen + 1'b1;
        if (w_all_take) begin
          r_all_fit   <= w_cand_fit;
          r_all_idx   <= w_cand_idx;
          r_all_gen   <= r_gen;
          r_all_valid <= 1'b1;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
    end else if (w_end) begin
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready         = w_ready;
  assign out_valid        = r_out_valid;
  assign best_index       = r_best_idx;
  assign best_fitness     = r_best_fit;
  assign gen_count        = r_gen_count;
  assign all_best_fitness = r_all_fit;
  assign all_best_index   = r_all_idx;
  assign all_best_gen     = r_all_gen;
  assign all_valid        = r_all_valid;
  assign len_err          = r_len_err;

endmodule

// File: tb/tb_best_stream.sv
// tb_best_stream: directed and random checks of best_stream
// against a queue-based generation model.
module tb_best_stream;
  localparam int W  = 27;
  localparam int NN = 16;
  localparam int IW = 8;
  localparam int GW = 16;

  logic clk = 1'b0;
  logic rst_n, clear, mode_min, in_valid, in_last, out_ready;
  logic signed [W-1:0] in_fitness;
  logic in_ready, out_valid, all_valid, len_err;
  logic [IW-1:0] best_index, all_best_index;
  logic signed [W-1:0] best_fitness, all_best_fitness;
  logic [GW-1:0] gen_count, all_best_gen;

  always #5 clk = ~clk;

  best_stream #(.WIDTH(W), .N(NN), .IDX_W(IW), .GEN_W(GW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .mode_min(mode_min),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fitness(in_fitness), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .best_index(best_index), .best_fitness(best_fitness),
    .gen_count(gen_count),
    .all_best_fitness(all_best_fitness),
    .all_best_index(all_best_index),
    .all_best_gen(all_best_gen),
    .all_valid(all_valid), .len_err(len_err)
  );

  int total = 0;
  int bad = 0;

  logic signed [W-1:0] q[$];
  logic signed [W-1:0] vals[NN];
  bit m_mode;
  int m_gen;
  bit m_ov;
  int m_bi;
  logic signed [W-1:0] m_bf;
  int m_gc;
  logic signed [W-1:0] m_af;
  int m_ai;
  int m_ag;
  bit m_av;
  bit m_le;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag,
             $signed(obs), $signed(exp));
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_mode = 0; m_gen = 0; m_ov = 0; m_bi = 0; m_bf = '0; m_gc = 0;
    m_af = '0; m_ai = 0; m_ag = 0; m_av = 0; m_le = 0;
  endtask

  task automatic check_all();
    chk("out_valid", out_valid, m_ov);
    chk("best_index", best_index, m_bi);
    chk("best_fitness", best_fitness, m_bf);
    chk("gen_count", gen_count, m_gc);
    chk("all_best_fitness", all_best_fitness, m_af);
    chk("all_best_index", all_best_index, m_ai);
    chk("all_best_gen", all_best_gen, m_ag);
    chk("all_valid", all_valid, m_av);
    chk("len_err", len_err, m_le);
  endtask

  task automatic cyc(input logic v, input logic signed [W-1:0] f,
                     input logic last, input logic ordy,
                     input logic mmin, input logic clr);
    bit acc;
    bit ended;
    int bi;
    in_valid = v; in_fitness = f; in_last = last;
    out_ready = ordy; mode_min = mmin; clear = clr;
    #1;
    chk("in_ready", in_ready, !m_ov || ordy);
    acc = v && (!m_ov || ordy) && !clr;
    ended = 0;
    @(posedge clk);
    #1;
    if (clr) begin
      q.delete();
      m_gen = 0; m_af = '0; m_ai = 0; m_ag = 0; m_av = 0;
    end else if (acc) begin
      if (q.size() == 0) m_mode = mmin;
      q.push_back(f);
      if (q.size() == NN || last) begin
        ended = 1;
        if ((q.size() == NN) != last) m_le = 1;
        bi = 0;
        for (int i = 1; i < q.size(); i++)
          if (m_mode ? (q[i] < q[bi]) : (q[i] > q[bi])) bi = i;
        m_bi = bi; m_bf = q[bi]; m_gc = m_gen;
        if (!m_av || (m_mode ? (q[bi] < m_af) : (q[bi] > m_af))) begin
          m_af = q[bi]; m_ai = bi; m_ag = m_gen; m_av = 1;
        end
        m_gen = (m_gen + 1) % 65536;
        q.delete();
      end
    end
    if (ended) m_ov = 1;
    else if (ordy) m_ov = 0;
    check_all();
  endtask

  task automatic feed(input int n, input int last_at,
                      input logic ordy, input logic mmin);
    for (int i = 0; i < n; i++)
      cyc(1'b1, vals[i], i == last_at, ordy, mmin, 1'b0);
  endtask

  task automatic do_rst();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic signed [W-1:0] rf;
    rst_n = 1'b0; clear = 0; mode_min = 0; in_valid = 0;
    in_last = 0; out_ready = 0; in_fitness = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // basic argmax
    for (int i = 0; i < NN; i++) vals[i] = W'(i * 3);
    vals[9] = 1000;
    feed(NN, NN - 1, 1, 0);
    chk("argmax_valid", out_valid, 1);
    chk("argmax_idx", best_index, 9);
    chk("argmax_fit", best_fitness, 1000);
    chk("argmax_gen", gen_count, 0);
    chk("argmax_allgen", all_best_gen, 0);

    // all most-negative
    for (int i = 0; i < NN; i++) vals[i] = 27'h400_0000;
    feed(NN, NN - 1, 1, 0);
    chk("neg_idx", best_index, 0);
    chk("neg_fit", best_fitness, -67108864);

    // ties keep the lowest index
    for (int i = 0; i < NN; i++) vals[i] = '0;
    vals[0] = 5; vals[1] = 7; vals[2] = 7;
    feed(NN, NN - 1, 1, 0);
    chk("tie_idx", best_index, 1);

    // minimum mode with all-time tracking
    cyc(0, '0, 0, 1, 0, 1);
    for (int i = 0; i < NN; i++) vals[i] = W'(100 + i);
    vals[3] = -50;
    feed(NN, NN - 1, 1, 1);
    for (int i = 0; i < NN; i++) vals[i] = W'(100 + i);
    vals[0] = -20;
    feed(NN, NN - 1, 1, 1);
    chk("min_best", best_fitness, -20);
    chk("min_all_fit", all_best_fitness, -50);
    chk("min_all_idx", all_best_index, 3);
    chk("min_all_gen", all_best_gen, 0);
    chk("min_gen", gen_count, 1);

    // back-pressure then gapless streaming
    for (int i = 0; i < NN; i++) vals[i] = W'($urandom);
    feed(NN, NN - 1, 1, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(1, W'($urandom), 0, 0, 0, 0);
      chk("bp_in_ready", in_ready, 0);
    end
    for (int i = 0; i < NN; i++) vals[i] = W'($urandom);
    feed(NN, NN - 1, 1, 0);
    chk("bp_second_valid", out_valid, 1);

    // short generation
    for (int i = 0; i < NN; i++) vals[i] = W'($urandom_range(0, 500));
    feed(10, 9, 1, 0);
    chk("short_len_err", len_err, 1);
    chk("short_valid", out_valid, 1);
    for (int i = 0; i < NN; i++) vals[i] = W'($urandom_range(0, 500));
    feed(NN, NN - 1, 1, 0);
    chk("after_len_err", len_err, 1);

    // clear at cnt=7
    feed(7, -1, 1, 0);
    cyc(1, 12345, 0, 1, 0, 1);
    chk("clr_all_valid", all_valid, 0);
    for (int i = 0; i < NN; i++) vals[i] = W'($urandom);
    feed(NN, NN - 1, 1, 0);
    chk("clr_gen", gen_count, 0);
    chk("clr_all_valid2", all_valid, 1);

    // reset mid-scan
    feed(5, -1, 1, 0);
    do_rst();
    chk("rst_valid", out_valid, 0);
    chk("rst_len_err", len_err, 0);

    // random traffic
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 1) == 0) rf = W'($urandom);
      else rf = W'($urandom_range(0, 4)) - 2;
      cyc($urandom_range(0, 3) != 0, rf, $urandom_range(0, 19) == 0,
          $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
          $urandom_range(0, 99) == 0);
      if (k == 400) do_rst();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
